// File: rtl/parity_pkg.sv
// Shared types and constants for the parity scheduler: FSM encoding,
// parity-sense encoding and a constant log2 helper.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EVAL = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/parityGen.sv
// Combinational parity tree: XOR reduction of an N-bit word.
module parityGen #(
    parameter int N = 8
) (
    input  logic [N-1:0] data,
    output logic         parity
);

    assign parity = ^data;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr,
// wrapping modulo R. The pointer itself lives in the caller.
module rr_arbiter
    import parity_pkg::*;
#(
    parameter int R  = 4,
    parameter int IW = 2
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [R-1:0]  grant,
    output logic [IW-1:0] gidx
);

    logic [IW-1:0] idx;
    logic          found;

    // R is a power of two, so IW-bit addition wraps exactly modulo R.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        if (en) begin
            for (int k = 0; k < R; k++) begin
                idx = ptr + IW'(k);
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    gidx       = idx;
                end
            end
        end
    end

endmodule

// File: rtl/parity_sched.sv
// Round-robin scheduler sharing one parityGen tree between R requesters,
// returning a registered, ID-tagged parity on a valid/ready channel.
//
//  state | meaning
//  IDLE  | arbitrate; capture granted word, id and advance ptr on grant
//  EVAL  | parity tree evaluates operand; result registered on the edge
//  RESP  | hold rsp_* until rsp_ready handshake, then back to IDLE
module parity_sched
    import parity_pkg::*;
#(
    parameter int N   = 8,
    parameter int R   = 4,
    parameter int ODD = 0,
    parameter int IW  = clog2(R)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req_valid,
    input  logic [R*N-1:0] req_data,
    output logic [R-1:0]   req_ready,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_parity,
    output logic [IW-1:0]  rsp_id,
    output logic [N-1:0]   rsp_data
);

    localparam logic ODD_BIT = (ODD == PAR_ODD);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gidx;
    logic [IW-1:0] id_q;
    logic [N-1:0]  operand;
    logic [R-1:0]  grant;
    logic          arb_en;
    logic          grant_any;
    logic          tree_out;
    logic          cap_req;
    logic          do_eval;
    logic          rsp_done;

    // Gating with rst_n keeps req_ready low for the whole reset pulse.
    assign arb_en    = rst_n && (state == IDLE);
    assign req_ready = grant;
    assign grant_any = |grant;

    rr_arbiter #(
        .R  (R),
        .IW (IW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (arb_en),
        .grant (grant),
        .gidx  (gidx)
    );

    parityGen #(
        .N (N)
    ) u_tree (
        .data   (operand),
        .parity (tree_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        cap_req   = 1'b0;
        do_eval   = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    cap_req   = 1'b1;
                    state_nxt = EVAL;
                end else begin
                    state_nxt = IDLE;
                end
            end
            EVAL: begin
                do_eval   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RESP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            id_q       <= '0;
            operand    <= '0;
            rsp_valid  <= 1'b0;
            rsp_parity <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
        end else begin
            if (cap_req) begin
                operand <= req_data[gidx*N +: N];
                id_q    <= gidx;
                ptr     <= gidx + IW'(1);
            end
            // id and data are published together with the parity so all
            // rsp_* fields change on the same edge.
            if (do_eval) begin
                rsp_parity <= tree_out ^ ODD_BIT;
                rsp_valid  <= 1'b1;
                rsp_id     <= id_q;
                rsp_data   <= operand;
            end
            if (rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parity_sched.sv
// Self-checking bench for parity_sched: directed scenarios plus randomized
// transactions against a transaction-level round-robin/parity model.
module tb_parity_sched;

    localparam int N  = 8;
    localparam int R  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [R-1:0]   req_valid;
    logic [R*N-1:0] req_data;
    logic [R-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_parity;
    logic [IW-1:0]  rsp_id;
    logic [N-1:0]   rsp_data;

    logic [R-1:0]   o_req_ready;
    logic           o_rsp_valid;
    logic           o_rsp_parity;
    logic [IW-1:0]  o_rsp_id;
    logic [N-1:0]   o_rsp_data;

    int passed = 0;
    int total  = 0;
    int mptr   = 0;

    always #5 clk = ~clk;

    parity_sched #(.N(N), .R(R), .ODD(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_parity (rsp_parity),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    parity_sched #(.N(N), .R(R), .ODD(1)) dut_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (o_req_ready),
        .rsp_valid  (o_rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_parity (o_rsp_parity),
        .rsp_id     (o_rsp_id),
        .rsp_data   (o_rsp_data)
    );

    function automatic int pick(input logic [R-1:0] v, input int p);
        for (int k = 0; k < R; k++) begin
            if (v[(p + k) % R]) return (p + k) % R;
        end
        return -1;
    endfunction

    function automatic logic par(input logic [N-1:0] d);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(d[i]);
        return (c % 2) == 1;
    endfunction

    function automatic logic [R-1:0] onehot(input int g);
        logic [R-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    task automatic set_word(input int r, input logic [N-1:0] d);
        req_data[r*N +: N] = d;
    endtask

    function automatic logic [N-1:0] word(input int r);
        return req_data[r*N +: N];
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mptr = 0;
    endtask

    // Returns inside the cycle preceding the grant edge.
    task automatic wait_grant(output logic [R-1:0] g, output bit ok);
        ok = 1'b0;
        g  = '0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_ready != '0) begin
                g  = req_ready;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n  = c;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [R-1:0] g;
        bit ok;
        int n;
        rst_n = 1'b0; req_valid = '1; req_data = '0; rsp_ready = 1'b0;
        #3;
        total++;
        if ({rsp_valid, rsp_parity, rsp_id, rsp_data, req_ready} !== '0)
            $display("FAIL reset_in_reset: got %0h required 0", {rsp_valid, rsp_parity, rsp_id, rsp_data, req_ready});
        else passed++;
        do_reset();
        set_word(2, 8'h89);
        req_valid = 4'b0100;
        wait_grant(g, ok);
        total++;
        if (!ok || g !== 4'b0100) $display("FAIL reset_pre_grant: got %b required 0100", g);
        else passed++;
        @(posedge clk); #1 req_valid = '0; mptr = 3;
        wait_rsp(n, ok);
        total++;
        if (!ok || rsp_id !== 2'd2 || rsp_data !== 8'h89)
            $display("FAIL reset_pre_rsp: got id %0d data %0h required 2 89", rsp_id, rsp_data);
        else passed++;
        set_word(1, 8'h55); set_word(3, 8'hC3);
        req_valid = 4'b1010;
        #1;
        total++;
        if (req_ready !== '0) $display("FAIL ready_in_resp: got %b required 0000", req_ready);
        else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({rsp_valid, rsp_parity, rsp_id, rsp_data, req_ready, o_rsp_parity} !== '0)
            $display("FAIL reset_async: got %0h required 0", {rsp_valid, rsp_parity, rsp_id, rsp_data, req_ready});
        else passed++;
        @(posedge clk); #1 rst_n = 1'b1; mptr = 0;
        wait_grant(g, ok);
        total++;
        if (!ok || g !== onehot(pick(4'b1010, mptr)))
            $display("FAIL reset_first_grant: got %b required %b", g, onehot(pick(4'b1010, mptr)));
        else passed++;
        @(posedge clk); #1 req_valid = '0; rsp_ready = 1'b1; mptr = 2;
        wait_rsp(n, ok);
        total++;
        if (!ok || rsp_id !== 2'd1 || rsp_data !== 8'h55 || rsp_parity !== par(8'h55))
            $display("FAIL reset_no_replay: got id %0d data %0h par %0b required 1 55 %0b", rsp_id, rsp_data, rsp_parity, par(8'h55));
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [R-1:0] g;
        bit ok;
        int n;
        rsp_ready = 1'b1;
        set_word(0, 8'h03);
        req_valid = 4'b0001;
        wait_grant(g, ok);
        total++;
        if (!ok || g !== 4'b0001) $display("FAIL single_grant: got %b required 0001", g);
        else passed++;
        @(posedge clk); #1 req_valid = '0; mptr = 1;
        wait_rsp(n, ok);
        total++;
        if (!ok || n != 2) $display("FAIL single_latency: got %0d required 2", n);
        else passed++;
        total++;
        if (rsp_parity !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 8'h03)
            $display("FAIL single_rsp: got par %0b id %0d data %0h required 0 0 03", rsp_parity, rsp_id, rsp_data);
        else passed++;
        total++;
        if (o_rsp_parity !== 1'b1 || o_rsp_data !== 8'h03 || o_rsp_id !== 2'd0 || !o_rsp_valid)
            $display("FAIL single_odd: got par %0b data %0h required 1 03", o_rsp_parity, o_rsp_data);
        else passed++;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || o_req_ready !== req_ready)
            $display("FAIL single_after_hs: got valid %0b required 0", rsp_valid);
        else passed++;
    endtask

    task automatic test_odd_word();
        logic [R-1:0] g;
        bit ok;
        int n;
        rsp_ready = 1'b1;
        set_word(1, 8'h89);
        req_valid = 4'b0010;
        wait_grant(g, ok);
        @(posedge clk); #1 req_valid = '0; mptr = 2;
        wait_rsp(n, ok);
        total++;
        if (!ok || rsp_parity !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'h89)
            $display("FAIL odd_word_even: got par %0b id %0d data %0h required 1 1 89", rsp_parity, rsp_id, rsp_data);
        else passed++;
        total++;
        if (o_rsp_parity !== 1'b0) $display("FAIL odd_word_odd: got %0b required 0", o_rsp_parity);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int exp_q[$];
        int got, last, cyc, e;
        do_reset();
        rsp_ready = 1'b1;
        set_word(0, 8'h01); set_word(1, 8'h03); set_word(2, 8'h07); set_word(3, 8'hFF);
        req_valid = 4'b1111;
        got = 0; last = 0;
        for (cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                e = pick(req_valid, mptr);
                total++;
                if (req_ready !== onehot(e)) $display("FAIL rr_grant: got %b required %b", req_ready, onehot(e));
                else passed++;
                exp_q.push_back(e);
                mptr = (e + 1) % R;
            end
            if (rsp_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                total++;
                if (int'(rsp_id) != e || rsp_data !== word(e) || rsp_parity !== par(word(e)))
                    $display("FAIL rr_rsp: got id %0d par %0b required id %0d par %0b", rsp_id, rsp_parity, e, par(word(e)));
                else passed++;
                if (got > 0) begin
                    total++;
                    if (cyc - last != 3) $display("FAIL rr_spacing: got %0d required 3", cyc - last);
                    else passed++;
                end
                last = cyc;
                got++;
            end
        end
        @(posedge clk); #1 req_valid = '0;
        total++;
        if (got != 5) $display("FAIL rr_count: got %0d required 5", got);
        else passed++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [R-1:0] g;
        bit ok;
        int n, changes, rdy;
        logic [N+IW:0] snap;
        do_reset();
        set_word(0, 8'hA5);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        wait_grant(g, ok);
        @(posedge clk); #1 req_valid = 4'b1000; set_word(3, 8'h3C); mptr = 1;
        wait_rsp(n, ok);
        snap = {rsp_parity, rsp_id, rsp_data};
        total++;
        if (!ok || snap !== {par(8'hA5), 2'd0, 8'hA5})
            $display("FAIL bp_rsp: got %0h required %0h", snap, {par(8'hA5), 2'd0, 8'hA5});
        else passed++;
        changes = 0; rdy = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if ({rsp_valid, rsp_parity, rsp_id, rsp_data} !== {1'b1, snap}) changes++;
            if (req_ready != '0) rdy++;
        end
        total++;
        if (changes != 0) $display("FAIL bp_hold: got %0d changes required 0", changes);
        else passed++;
        total++;
        if (rdy != 0) $display("FAIL bp_no_grant: got %0d grants required 0", rdy);
        else passed++;
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== onehot(pick(4'b1000, mptr)))
            $display("FAIL bp_release: got valid %0b ready %b required 0 1000", rsp_valid, req_ready);
        else passed++;
        @(posedge clk); #1 req_valid = '0; mptr = 0;
        wait_rsp(n, ok);
        total++;
        if (!ok || rsp_id !== 2'd3 || rsp_data !== 8'h3C || rsp_parity !== par(8'h3C))
            $display("FAIL bp_second: got id %0d data %0h required 3 3c", rsp_id, rsp_data);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_wrap_sparse();
        logic [R-1:0] g;
        bit ok;
        int n, k;
        int exp_seq[3];
        exp_seq[0] = 3; exp_seq[1] = 1; exp_seq[2] = 3;
        do_reset();
        rsp_ready = 1'b1;
        set_word(2, 8'h11);
        req_valid = 4'b0100;
        wait_grant(g, ok);
        @(posedge clk); #1 req_valid = '0; mptr = 3;
        wait_rsp(n, ok);
        set_word(1, 8'h21); set_word(3, 8'h7E);
        req_valid = 4'b1010;
        k = 0;
        for (int c = 0; c < 30 && k < 3; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                total++;
                if (req_ready !== onehot(exp_seq[k]) || req_ready !== onehot(pick(req_valid, mptr)))
                    $display("FAIL wrap_grant%0d: got %b required %b", k, req_ready, onehot(exp_seq[k]));
                else passed++;
                mptr = (exp_seq[k] + 1) % R;
                k++;
                if (k == 3) begin
                    @(posedge clk); #1 req_valid = 4'b1000;
                end
            end
        end
        total++;
        if (k != 3) $display("FAIL wrap_count: got %0d required 3", k);
        else passed++;
        wait_grant(g, ok);
        total++;
        if (!ok || g !== 4'b1000) $display("FAIL wrap_dropped: got %b required 1000", g);
        else passed++;
        @(posedge clk); #1 req_valid = '0; mptr = 0;
        wait_rsp(n, ok);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [R-1:0] g, mask;
        bit ok;
        int n, e, stall;
        for (int t = 0; t < 40; t++) begin
            mask = R'($urandom_range(1, (1 << R) - 1));
            for (int r = 0; r < R; r++) set_word(r, N'($urandom));
            req_valid = mask;
            e = pick(mask, mptr);
            wait_grant(g, ok);
            total++;
            if (!ok || g !== onehot(e)) $display("FAIL rand_grant%0d: got %b required %b", t, g, onehot(e));
            else passed++;
            stall = $urandom_range(0, 3);
            @(posedge clk); #1 req_valid = '0; rsp_ready = (stall == 0); mptr = (e + 1) % R;
            wait_rsp(n, ok);
            total++;
            if (!ok || n != 2 || int'(rsp_id) != e || rsp_data !== word(e) || rsp_parity !== par(word(e))
                || o_rsp_parity !== ~par(word(e)))
                $display("FAIL rand_rsp%0d: got lat %0d id %0d data %0h par %0b required 2 %0d %0h %0b",
                         t, n, rsp_id, rsp_data, rsp_parity, e, word(e), par(word(e)));
            else passed++;
            if (stall > 0) begin
                repeat (stall) @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0) $display("FAIL rand_hs%0d: got valid %0b required 0", t, rsp_valid);
            else passed++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_odd_word();
        test_round_robin();
        test_backpressure();
        test_wrap_sparse();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
